led_shifter: RTL
================

LED_SHIFTER -- requirements
Module: led_shifter

Interface
REQ-001 Parameter WIDTH, default 16, number of LEDs (legal 2..64).
REQ-002 Parameter START_POS, default WIDTH-1, lit LED index after reset.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles needed to accept a level change (legal >=1).
REQ-004 Parameter WRAP, default 0: 0 saturates at the ends, 1 wraps around.
REQ-005 Parameter REPEAT_DELAY, default 50_000_000, hold cycles before the first auto-repeat step.
REQ-006 Parameter REPEAT_PERIOD, default 10_000_000, cycles between subsequent auto-repeat steps.
REQ-007 clk  input  1  single clock, all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 btnR  input  1  raw asynchronous button, move toward index 0.
REQ-010 btnL  input  1  raw asynchronous button, move toward index WIDTH-1.
REQ-011 led  output  WIDTH  one-hot LED vector, registered.
REQ-012 pos  output  $clog2(WIDTH)  binary index of the lit LED, registered, always consistent with led.
REQ-013 edge_hit  output  1  one-cycle pulse when a step is requested but blocked at an end (WRAP=0 only).

Function
REQ-014 Each button passes through a 2-flop synchroniser before any other logic.
REQ-015 Debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 A step request is a one-cycle pulse on the debounced 0->1 transition.
REQ-017 Latency: a clean press stable from edge N produces the led update at edge N+2+DEBOUNCE_CYCLES+1.
REQ-018 Right step: pos-1, led shifted right; left step: pos+1, led shifted left.
REQ-019 WRAP=0: right step at pos 0 or left step at pos WIDTH-1 leaves led/pos unchanged and pulses edge_hit for one cycle.
REQ-020 WRAP=1: right step at pos 0 goes to WIDTH-1; left step at WIDTH-1 goes to 0; edge_hit stays 0.
REQ-021 Right and left step requests in the same cycle cancel: no movement, no edge_hit.
REQ-022 led is exactly one-hot at all times after reset; no cycle with zero or two lit LEDs.
REQ-023 Release produces no step; debounced 1->0 only re-arms the press detector.

Reset
REQ-024 rst_n low asynchronously forces led = 1<<START_POS, pos = START_POS, edge_hit = 0, synchronisers, debounced levels and all counters to 0.
REQ-025 Reset asserted mid-debounce or mid-hold discards the pending press; a button still held at reset release needs a full debounce and counts as a new press.

Configuration
REQ-026 Macro LED_SHIFTER_AUTOREPEAT_EN defined: a button whose debounced level stays 1 issues an extra step REPEAT_DELAY cycles after its press pulse, then every REPEAT_PERIOD cycles until release; repeats obey REQ-019..REQ-021.
REQ-027 Macro undefined: exactly one step per press; repeat counters and REPEAT_* parameters have no effect and no hardware.

Structure
REQ-028 Package led_shifter_pkg holds the direction typedef (DIR_NONE, DIR_RIGHT, DIR_LEFT) and the default-parameter constants.
REQ-029 Sub-module btn_conditioner (synchroniser, debounce counter, press pulse, optional repeat timer) instantiated once per button.
REQ-030 Position/led register update lives in led_shifter; pos and led are updated in the same edge.

Verification
REQ-031 Bench uses WIDTH=16, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
REQ-032 Reset release, one clean btnR press -> led 0x8000 then 0x4000 at edge N+7, pos 15->14.
REQ-033 btnR pulsed high 3 cycles twice with 1-cycle gaps, then stable -> exactly one step, only after 4 stable cycles.
REQ-034 WRAP=0, pos 0, btnR press -> led stays 0x0001, edge_hit one cycle; WRAP=1 same stimulus -> led 0x8000, pos 15.
REQ-035 btnR and btnL debounced on the same cycle -> led unchanged, edge_hit 0.
REQ-036 AUTOREPEAT_EN, btnL held 50 cycles from pos 0 -> steps at press, +20, +28, +36, +44: pos 5; without macro pos 1.
REQ-037 rst_n pulsed low during btnL debounce at pos 3 -> led 0x8000 immediately, no step until 4 stable cycles after release.

Source files
------------

// File: rtl/led_shifter_pkg.sv
// led_shifter_pkg: shared types and default configuration for the LED shifter.
//   dir_e        : step direction decoded from the two conditioned buttons
//   DEF_*        : default parameter values for led_shifter / btn_conditioner
//   step_dir()   : folds the right/left step pulses into one direction
//                  (simultaneous requests cancel)
package led_shifter_pkg;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  localparam int DEF_WIDTH           = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_WRAP            = 0;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

  function automatic dir_e step_dir(input logic r, input logic l);
    if (r && !l) return DIR_RIGHT;
    if (l && !r) return DIR_LEFT;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/led_shifter_if.sv
// led_shifter_if: button inputs and LED outputs of the shifter.
//   btnR, btnL : raw asynchronous buttons (right = toward index 0)
//   led        : one-hot LED vector
//   pos        : binary index of the lit LED
//   edge_hit   : one-cycle pulse when a step is blocked at an end
// Modports: master drives the buttons (board / bench), slave is the shifter.
interface led_shifter_if
  import led_shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int PW = $clog2(WIDTH);

  logic             btnR;
  logic             btnL;
  logic [WIDTH-1:0] led;
  logic [PW-1:0]    pos;
  logic             edge_hit;

  modport master (output btnR, btnL, input led, pos, edge_hit);
  modport slave  (input btnR, btnL, output led, pos, edge_hit);
endinterface

// File: rtl/led_shifter_btn_conditioner.sv
// btn_conditioner: turns one raw button into a one-cycle step request.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   step       : one-cycle step request
// Path: 2-flop synchroniser -> debounce counter -> registered press pulse.
// With LED_SHIFTER_AUTOREPEAT_EN defined, a held button also issues repeat
// steps REPEAT_DELAY cycles after the press and every REPEAT_PERIOD after.
module btn_conditioner
  import led_shifter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_conditioner: timing parameters must be >= 1");
  end

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic          level, level_q;
  logic          press;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // count consecutive cycles the synchronised level disagrees with the
      // accepted level; any agreeing cycle (bounce) restarts the count
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        level  <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
      level_q <= level;
      // registered rise detect; a release only re-arms this detector
      press   <= level & ~level_q;
    end
  end

`ifdef LED_SHIFTER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic          running;
  logic [RW-1:0] rpt_cnt;
  logic          rpt;

  // counter reaches zero exactly REPEAT_DELAY cycles after the press cycle,
  // then is reloaded for each following period
  assign rpt = running & level & (rpt_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      rpt_cnt <= '0;
    end else if (!level) begin
      running <= 1'b0;
      rpt_cnt <= '0;
    end else if (press) begin
      running <= 1'b1;
      rpt_cnt <= RW'(REPEAT_DELAY - 1);
    end else if (running) begin
      rpt_cnt <= (rpt_cnt == '0) ? RW'(REPEAT_PERIOD - 1) : rpt_cnt - RW'(1);
    end
  end

  assign step = press | rpt;
`else
  assign step = press;
`endif

endmodule

// File: rtl/led_shifter.sv
// led_shifter: moves a single lit LED left/right on debounced button presses.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : led_shifter_if.slave (btnR/btnL in, led/pos/edge_hit out)
// WRAP=0 saturates at the ends and pulses edge_hit; WRAP=1 wraps around.
// Simultaneous right/left requests cancel.
// Optional feature macro: LED_SHIFTER_AUTOREPEAT_EN (auto-repeat while held).
module led_shifter
  import led_shifter_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int START_POS       = WIDTH - 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WRAP            = DEF_WRAP,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic          clk,
  input logic          rst_n,
  led_shifter_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 64 || START_POS < 0 || START_POS >= WIDTH) begin : g_bad_cfg
    $error("led_shifter: WIDTH must be 2..64 and START_POS inside it");
  end

  localparam int               PW      = $clog2(WIDTH);
  localparam logic [PW-1:0]    POS_MAX = PW'(WIDTH - 1);
  localparam logic [PW-1:0]    POS_RST = PW'(START_POS);
  localparam logic [WIDTH-1:0] LED_RST = WIDTH'(1) << START_POS;

  logic step_r, step_l;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_btn_r (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btnR),
    .step  (step_r)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_btn_l (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btnL),
    .step  (step_l)
  );

  dir_e             dir;
  logic [PW-1:0]    pos_q, pos_nxt;
  logic [WIDTH-1:0] led_q;
  logic             hit_q, hit_nxt;

  assign dir = step_dir(step_r, step_l);

  always_comb begin
    pos_nxt = pos_q;
    hit_nxt = 1'b0;
    case (dir)
      DIR_RIGHT: begin
        if (pos_q == '0) begin
          if (WRAP != 0) pos_nxt = POS_MAX;
          else           hit_nxt = 1'b1;
        end else begin
          pos_nxt = pos_q - PW'(1);
        end
      end
      DIR_LEFT: begin
        if (pos_q == POS_MAX) begin
          if (WRAP != 0) pos_nxt = '0;
          else           hit_nxt = 1'b1;
        end else begin
          pos_nxt = pos_q + PW'(1);
        end
      end
      default: ;
    endcase
  end

  // led is re-derived from the same next index as pos so the two can never
  // disagree or leave the one-hot form
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= POS_RST;
      led_q <= LED_RST;
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_nxt;
      if (dir != DIR_NONE) begin
        pos_q <= pos_nxt;
        led_q <= WIDTH'(1) << pos_nxt;
      end
    end
  end

  assign bus.led      = led_q;
  assign bus.pos      = pos_q;
  assign bus.edge_hit = hit_q;

endmodule
